// File: rtl/draw_sweep_ctrl.sv
// Address-pair sweep controller: emits {idx,0}/{idx,1} pairs over a valid/ready link.
// Optional abort input is enabled by defining DRAW_SWEEP_ABORT_EN.
module draw_sweep_ctrl #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-2:0] base_idx,
    input  logic [LEN_W-1:0]  pair_count,
    input  logic              ready,
`ifdef DRAW_SWEEP_ABORT_EN
    input  logic              abort,
`endif
    output logic              valid,
    output logic [ADDR_W-1:0] Q_a,
    output logic [ADDR_W-1:0] Q_b,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    localparam int IDX_W = ADDR_W - 1;

    // Link protocol: a pair transfers on any rising edge where valid && ready;
    // while valid && !ready the pair on Q_a/Q_b is held unchanged; valid is
    // never withdrawn before its pair is accepted, except by reset or abort.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             hs;
    logic             abort_w;

`ifdef DRAW_SWEEP_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign hs = (state_q == S_RUN) && ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = base_idx;
                    rem_d   = pair_count;
                    state_d = (pair_count != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (hs) begin
                    rem_d = rem_q - LEN_W'(1);
                    // The final pair (or an aborted one) leaves idx on the last emitted index.
                    if (rem_q > LEN_W'(1) && !abort_w) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (abort_w) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign valid       = (state_q == S_RUN);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign Q_a         = {idx_q, 1'b0};
    assign Q_b         = {idx_q, 1'b1};
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_draw_sweep_ctrl.sv
// Randomized directed bench for draw_sweep_ctrl against a list-of-pairs reference model.
// Define DRAW_SWEEP_ABORT_EN to also exercise the abort input.
module tb_draw_sweep_ctrl;

    localparam int ADDR_W = 14;
    localparam int LEN_W  = 9;
    localparam int IDX_MOD = 1 << (ADDR_W - 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-2:0] base_idx;
    logic [LEN_W-1:0]  pair_count;
    logic              ready;
    logic              valid;
    logic [ADDR_W-1:0] Q_a;
    logic [ADDR_W-1:0] Q_b;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;
`ifdef DRAW_SWEEP_ABORT_EN
    logic              abort;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] exp_q[$];
    bit rdy_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    draw_sweep_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_idx   (base_idx),
        .pair_count (pair_count),
        .ready      (ready),
`ifdef DRAW_SWEEP_ABORT_EN
        .abort      (abort),
`endif
        .valid      (valid),
        .Q_a        (Q_a),
        .Q_b        (Q_b),
        .busy       (busy),
        .done       (done),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // scoreboard comparison
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // model: the ordered list of even addresses a sweep must present
    task automatic load_model(input int b, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(ADDR_W'(((b + k) % IDX_MOD) * 2));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // driver: rmode 0 = ready always 1, 1 = random ready, 2 = fixed pattern
    task automatic run_sweep(input int b, input int n, input int rmode, input bit stray);
        int budget;
        int pat_i;
        int hs;
        logic [ADDR_W-1:0] last_qa;
        bit r;
        load_model(b, n);
        last_qa = ADDR_W'((b % IDX_MOD) * 2);
        hs = 0;
        pat_i = 0;
        @(negedge clk);
        base_idx = ADDR_W'(b) - 0; pair_count = LEN_W'(n); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        base_idx = ($urandom_range(0, IDX_MOD - 1));
        pair_count = ($urandom_range(0, 511));
        budget = 4 * n + 16;
        while (exp_q.size() > 0 && budget > 0) begin
            chk("run_valid", valid, 1);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_q_a", Q_a, exp_q[0]);
            chk("run_q_b", Q_b, exp_q[0] + 1);
            if (rmode == 0) r = 1'b1;
            else if (rmode == 1) r = 1'($urandom_range(0, 1));
            else r = rdy_pat[pat_i % 6];
            pat_i++;
            ready = r;
            if (stray) begin
                start = ($urandom_range(0, 3) == 0);
                base_idx = ($urandom_range(0, IDX_MOD - 1));
                pair_count = ($urandom_range(0, 511));
            end
            if (r) begin
                last_qa = exp_q.pop_front();
                hs++;
            end
            @(posedge clk);
            @(negedge clk);
            budget--;
        end
        chk("pairs_left", exp_q.size(), 0);
        chk("handshakes", hs, n);
        ready = 1'b0;
        chk("done_valid", valid, 0);
        chk("done_busy", busy, 1);
        chk("done_pulse", done, 1);
        start = 1'b1;
        base_idx = ($urandom_range(0, IDX_MOD - 1));
        pair_count = 1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk_idle("after_done");
        chk("hold_q_a", Q_a, last_qa);
        chk("hold_q_b", Q_b, last_qa + 1);
        @(posedge clk);
        @(negedge clk);
        chk_idle("idle2");
        chk("idle2_q_a", Q_a, last_qa);
    endtask

    initial begin
        int b;
        int n;
        reset = 1'b0; start = 1'b0; ready = 1'b0; base_idx = '0; pair_count = '0;
`ifdef DRAW_SWEEP_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        chk_idle("reset");
        chk("reset_q_a", Q_a, 0);
        chk("reset_q_b", Q_b, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        run_sweep(7296, 128, 0, 1'b0);
        run_sweep(10, 3, 2, 1'b0);
        run_sweep($urandom_range(0, IDX_MOD - 1), 0, 0, 1'b0);
        run_sweep(8191, 2, 1, 1'b0);

        // reset during the 5th pair of a 20-pair sweep
        b = $urandom_range(0, IDX_MOD - 1);
        load_model(b, 20);
        @(negedge clk);
        base_idx = ADDR_W'(b) - 0; pair_count = 20; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_sweep_q_a", Q_a, exp_q[0]);
            void'(exp_q.pop_front());
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_5th_valid", valid, 1);
        chk("rst_5th_q_a", Q_a, exp_q[0]);
        #2 reset = 1'b0;
        #1;
        chk_idle("async_reset");
        chk("async_reset_q_a", Q_a, 0);
        chk("async_reset_q_b", Q_b, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk_idle("abandoned");
        end

        for (int t = 0; t < 10; t++) begin
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            run_sweep($urandom_range(0, IDX_MOD - 1), n, 1, 1'b1);
        end
        run_sweep(IDX_MOD - 3, 6, 1, 1'b1);

`ifdef DRAW_SWEEP_ABORT_EN
        for (int t = 0; t < 2; t++) begin
            int hs_obs;
            bit r;
            b = $urandom_range(0, IDX_MOD - 1);
            r = bit'(t);
            load_model(b, 10);
            hs_obs = 0;
            @(negedge clk);
            base_idx = ADDR_W'(b) - 0; pair_count = 10; start = 1'b1;
            abort = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            chk("abort_idle_ignored", valid, 1);
            for (int k = 0; k < 4; k++) begin
                chk("abort_q_a", Q_a, exp_q[0]);
                ready = (k < 3) ? 1'b1 : r;
                abort = (k == 3);
                if (valid && ready) hs_obs++;
                if (ready) void'(exp_q.pop_front());
                @(posedge clk);
                @(negedge clk);
            end
            abort = 1'b0;
            ready = 1'b0;
            chk("abort_valid_drop", valid, 0);
            chk("abort_done", done, 1);
            chk("abort_hs", hs_obs, 3 + int'(r));
            @(posedge clk);
            @(negedge clk);
            chk_idle("abort_after");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/draw_sweep_ctrl.md
DRAW_SWEEP_CTRL -- requirements
Module: draw_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, meaning the memory address width; the pair index is ADDR_W-1 bits.
REQ-002 The block SHALL have parameter LEN_W, default 9, meaning the width of the pair count.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port start SHALL be an input, 1 bit wide: sweep request, sampled in IDLE only.
REQ-006 Port base_idx SHALL be an input, ADDR_W-1 bits wide: first pair index, latched on accepted start.
REQ-007 Port pair_count SHALL be an input, LEN_W bits wide: number of address pairs, latched on accepted start.
REQ-008 Port ready SHALL be an input, 1 bit wide: the downstream accepts the current pair this cycle.
REQ-009 Port valid SHALL be an output, 1 bit wide: Q_a/Q_b carry a pair to be consumed.
REQ-010 Port Q_a SHALL be an output, ADDR_W bits wide: even address {idx,1'b0}.
REQ-011 Port Q_b SHALL be an output, ADDR_W bits wide: odd address {idx,1'b1}.
REQ-012 Port busy SHALL be an output, 1 bit wide: high in RUN and DONE.
REQ-013 Port done SHALL be an output, 1 bit wide: one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 SHALL latch idx<=base_idx and rem<=pair_count, then go to RUN if pair_count!=0, else to DONE.
REQ-016 A start while not in IDLE SHALL be ignored, with no queuing.
REQ-017 valid SHALL be 1 exactly while in RUN, with zero-cycle latency from state entry.
REQ-018 A handshake SHALL occur on valid&&ready; Q_a/Q_b SHALL hold stable while valid&&!ready.
REQ-019 On a handshake with rem>1: idx<=idx+1 and rem<=rem-1, staying in RUN; each accepted pair occupies one cycle, so full rate is one pair per clock.
REQ-020 On a handshake with rem==1: go to DONE; idx SHALL NOT advance.
REQ-021 idx SHALL wrap modulo 2^(ADDR_W-1): an increment from all-ones yields 0, and the wrap is not flagged.
REQ-022 DONE SHALL assert done=1 for exactly one cycle and then return unconditionally to IDLE; start in DONE is ignored.
REQ-023 Outside RUN, Q_a/Q_b SHALL hold the last idx value.
REQ-024 A sweep of N>0 pairs SHALL produce exactly N handshakes and exactly one done pulse.

Reset
REQ-025 reset=0 SHALL immediately force state=IDLE, idx=0, rem=0, valid=0, busy=0 and done=0, with Q_a=0 and Q_b=1.
REQ-026 reset asserted mid-sweep SHALL abandon the sweep without a done pulse; after release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-027 Macro DRAW_SWEEP_ABORT_EN, when defined, SHALL add a 1-bit input port abort: abort=1 in RUN forces DONE next cycle.
REQ-028 With DRAW_SWEEP_ABORT_EN defined, a handshake in the same cycle as abort SHALL still count as consumed, but the sweep SHALL end; abort in IDLE or DONE SHALL have no effect.
REQ-029 Without DRAW_SWEEP_ABORT_EN, the abort port SHALL NOT exist and every started sweep SHALL run to completion.

Verification
REQ-030 base_idx=7296, pair_count=128, ready=1 constantly -> Q_a=14592,14594..14846 and Q_b=14593..14847 on consecutive cycles, then done for 1 cycle after the 128th handshake.
REQ-031 base_idx=10, pair_count=3, ready toggling 1,0,0,1,0,1 -> pairs (20,21),(22,23),(24,25); each held while ready=0; exactly 3 handshakes.
REQ-032 pair_count=0 with start -> valid stays 0; DONE entered next cycle; done=1 for one cycle; busy high only that cycle.
REQ-033 base_idx=8191, pair_count=2 -> Q_a=16382, then Q_a=0 and Q_b=1 (wrap); then done.
REQ-034 reset pulsed low during the 5th pair of a 20-pair sweep -> all outputs take reset values asynchronously; no done; a subsequent start runs normally; a start pulsed mid-sweep is ignored.
REQ-035 With DRAW_SWEEP_ABORT_EN defined, abort=1 at pair 4 of 10 -> valid drops the next cycle; done pulses once; handshake count is 4 if ready=1 on the abort cycle, else 3.
